scc_mem_responder: RTL

Memory-side responder for the single-cycle computer (SCC): it answers the SCC's instruction-fetch and data-access ports from internal instruction and data arrays. After reset it runs a byte-serial boot loader that fills instruction memory and holds the CPU until loading completes. It sits beside the SCC at top level, wired port-for-port to the SCC's `in_mem*` and `data*` signals.

---
 rtl/scc_mem_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/scc_mem_responder.sv
// Memory-side responder for the single-cycle computer: combinational instruction/data
// reads, clocked data writes, and a byte-serial boot loader that fills instruction memory.
module scc_mem_responder #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic        load_done,
  input  logic [31:0] in_mem_addr,
  input  logic        in_mem_en,
  output logic [31:0] in_mem,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        addr_fault
);

  localparam int IDEPTH = 1 << IMEM_AW;
  localparam int DDEPTH = 1 << DMEM_AW;

  typedef enum logic [1:0] {
    S_HDR0 = 2'd0,
    S_HDR1 = 2'd1,
    S_DATA = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0] r_count;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word_buf;
  logic        r_fault;

  logic [31:0] r_imem [0:IDEPTH-1];
  logic [31:0] r_dmem [0:DDEPTH-1];

  logic               w_run;
  logic               w_xfer;
  logic               w_ivalid;
  logic               w_dvalid;
  logic [IMEM_AW-1:0] w_iidx;
  logic [DMEM_AW-1:0] w_didx;
  logic [31:0]        w_word;
  logic               w_word_done;
  logic               w_in_range;
  logic               w_last_word;
  logic               w_imem_wr;
  logic               w_dmem_wr;
  logic               w_set_fault;

  // Word-aligned and within the array; anything else is an access error.
  function automatic logic addr_ok(input logic [31:0] a, input int aw);
    addr_ok = (a[1:0] == 2'b00) && ((a >> (aw + 2)) == 32'd0);
  endfunction

  // Decode of loader handshake, address checks and write enables.
  always_comb begin
    w_run       = (r_state == S_RUN);
    w_xfer      = load_valid && !w_run;
    w_ivalid    = addr_ok(in_mem_addr, IMEM_AW);
    w_dvalid    = addr_ok(data_addr, DMEM_AW);
    w_iidx      = in_mem_addr[IMEM_AW+1:2];
    w_didx      = data_addr[DMEM_AW+1:2];
    w_word      = {load_byte, r_word_buf};
    w_word_done = w_xfer && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
    w_in_range  = ((r_word_cnt >> IMEM_AW) == 16'd0);
    w_last_word = (r_word_cnt == (r_count - 16'd1));
    w_imem_wr   = w_word_done && w_in_range;
    w_dmem_wr   = w_run && data_write && w_dvalid;
    w_set_fault = (w_word_done && !w_in_range)
               || (w_run && in_mem_en && !w_ivalid)
               || (w_run && (data_read || data_write) && !w_dvalid);
  end

  // Loader next-state logic; transitions happen on the accepting edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_xfer) begin
          w_state_nxt = S_HDR1;
        end else begin
          w_state_nxt = S_HDR0;
        end
      end
      S_HDR1: begin
        if (w_xfer) begin
          w_state_nxt = ({load_byte, r_count[7:0]} == 16'd0) ? S_RUN : S_DATA;
        end else begin
          w_state_nxt = S_HDR1;
        end
      end
      S_DATA: begin
        if (w_word_done && w_last_word) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_HDR0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Header capture, byte assembly and word counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= 16'd0;
      r_word_cnt <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_word_buf <= 24'd0;
    end else if (w_xfer) begin
      case (r_state)
        S_HDR0: r_count[7:0]  <= load_byte;
        S_HDR1: r_count[15:8] <= load_byte;
        S_DATA: begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
          case (r_byte_cnt)
            2'd0:    r_word_buf[7:0]   <= load_byte;
            2'd1:    r_word_buf[15:8]  <= load_byte;
            2'd2:    r_word_buf[23:16] <= load_byte;
            default: r_word_cnt        <= r_word_cnt + 16'd1;
          endcase
        end
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky access-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_set_fault) begin
      r_fault <= 1'b1;
    end
  end

  // Memory arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (w_imem_wr) begin
      r_imem[r_word_cnt[IMEM_AW-1:0]] <= w_word;
    end
    if (w_dmem_wr) begin
      r_dmem[w_didx] <= data_out;
    end
  end

  // Status flags and zero-latency reads; CPU sees zeros while held.
  always_comb begin
    load_ready = !w_run;
    cpu_hold   = !w_run;
    load_done  = w_run;
    addr_fault = r_fault;
    if (w_run && in_mem_en && w_ivalid) begin
      in_mem = r_imem[w_iidx];
    end else begin
      in_mem = 32'd0;
    end
    if (w_run && data_read && w_dvalid) begin
      data_in = r_dmem[w_didx];
    end else begin
      data_in = 32'd0;
    end
  end

endmodule
